gate_sweep_checker: RTL and testbench



---
 rtl/gate_sweep_checker.sv | 131 +++++++++++++
 tb/tb_gate_sweep_checker.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: drives a 2-input gate through patterns 00, 01, 10, 11,
// holds each for SETTLE cycles, samples the gate output once per pattern and
// compares it against the TRUTH table. Results are reported through a
// start/busy/done handshake and held until the next accepted start.
module gate_sweep_checker #(
    parameter logic [3:0] TRUTH  = 4'b0111,  // expected Y, bit index = {A,B}
    parameter int         SETTLE = 2         // hold cycles per pattern, 1..255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       gate_y,
    output logic       gate_a,
    output logic       gate_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [3:0] fail_vec
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Settle counter value on the last DRIVE cycle of a pattern.
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    state_t     state_q;
    logic [1:0] idx_q;
    logic [7:0] scnt_q;
    logic       gate_a_q;
    logic       gate_b_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [2:0] err_cnt_q;
    logic [3:0] fail_vec_q;

    logic       mismatch_d;
    logic [1:0] idx_d;
    logic [2:0] err_cnt_d;
    logic [3:0] fail_vec_d;

    // Result update for the pattern currently being sampled; only committed
    // in SAMPLE, so gate_y is ignored in every other state.
    always_comb begin
        mismatch_d = (gate_y != TRUTH[idx_q]);
        idx_d      = idx_q + 2'd1;
        err_cnt_d  = err_cnt_q + {2'b00, mismatch_d};
        fail_vec_d = fail_vec_q | (4'(mismatch_d) << idx_q);
    end

    // Sweep sequencer with registered outputs; outputs are loaded together
    // with the state they belong to so they change on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            scnt_q     <= 8'd0;
            gate_a_q   <= 1'b0;
            gate_b_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= 3'd0;
            fail_vec_q <= 4'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    gate_a_q <= 1'b0;
                    gate_b_q <= 1'b0;
                    busy_q   <= 1'b0;
                    if (start) begin
                        err_cnt_q  <= 3'd0;
                        fail_vec_q <= 4'd0;
                        pass_q     <= 1'b0;
                        idx_q      <= 2'd0;
                        scnt_q     <= 8'd0;
                        busy_q     <= 1'b1;
                        state_q    <= DRIVE;
                    end
                end
                DRIVE: begin
                    scnt_q <= scnt_q + 8'd1;
                    if (scnt_q == SETTLE_LAST) begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    err_cnt_q  <= err_cnt_d;
                    fail_vec_q <= fail_vec_d;
                    if (idx_q == 2'd3) begin
                        gate_a_q <= 1'b0;
                        gate_b_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        idx_q    <= idx_d;
                        gate_a_q <= idx_d[1];
                        gate_b_q <= idx_d[0];
                        scnt_q   <= 8'd0;
                        state_q  <= DRIVE;
                    end
                end
                DONE: begin
                    // err_cnt already includes the pattern-3 result here.
                    pass_q  <= (err_cnt_q == 3'd0);
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gate_a   = gate_a_q;
    assign gate_b   = gate_b_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_cnt_q;
    assign fail_vec = fail_vec_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Testbench for gate_sweep_checker: the gate under test is a lookup table
// driven from the DUT's A/B outputs. A timeline model (position within the
// sweep, counted in cycles since the accepted start) predicts every output
// each cycle; directed sweeps pin the model with literal expectations.
module tb_gate_sweep_checker;

    localparam logic [3:0] TRUTH  = 4'b0111;
    localparam int         S      = 2;
    localparam int         P      = S + 1;      // cycles per pattern
    localparam int         LAST   = 4 * P;      // last busy cycle
    localparam int         DONE_T = 4 * P + 1;  // done cycle

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       gate_y;
    logic       gate_a, gate_b, busy, done, pass;
    logic [2:0] err_cnt;
    logic [3:0] fail_vec;
    logic [3:0] gate_fn = 4'b0111;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    // Combinational gate under test.
    assign gate_y = gate_fn[{gate_a, gate_b}];

    gate_sweep_checker #(.TRUTH(TRUTH), .SETTLE(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .gate_y(gate_y),
        .gate_a(gate_a), .gate_b(gate_b), .busy(busy), .done(done),
        .pass(pass), .err_cnt(err_cnt), .fail_vec(fail_vec)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Model: m_t is the cycle number within the current sweep (-1 = idle).
    int         m_t    = -1;
    logic [3:0] m_fail = 4'd0;
    logic [2:0] m_err  = 3'd0;
    logic       m_pass = 1'b0;

    always @(posedge clk) begin
        automatic int         t = m_t;
        automatic logic [3:0] f = m_fail;
        automatic logic [2:0] e = m_err;
        automatic logic       p = m_pass;
        automatic int         k;
        if (!rst_n) begin
            t = -1; f = 4'd0; e = 3'd0; p = 1'b0;
        end else if (t < 0) begin
            if (start) begin
                t = 1; f = 4'd0; e = 3'd0; p = 1'b0;
            end
        end else begin
            if (t <= LAST && (t % P) == 0) begin
                k = t / P - 1;
                if (gate_fn[k] !== TRUTH[k]) begin
                    f[k] = 1'b1;
                    e = e + 3'd1;
                end
            end
            if (t == DONE_T) begin
                p = (e == 3'd0);
                t = -1;
            end else begin
                t = t + 1;
            end
        end
        m_t    <= t;
        m_fail <= f;
        m_err  <= e;
        m_pass <= p;
    end

    // Compare every output against the model each cycle, away from the edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            automatic logic ea = 1'b0, eb = 1'b0, ebusy = 1'b0, edone = 1'b0;
            automatic int   k;
            if (m_t >= 1 && m_t <= LAST) begin
                k = (m_t - 1) / P;
                ea = k[1]; eb = k[0]; ebusy = 1'b1;
            end else if (m_t == DONE_T) begin
                edone = 1'b1;
            end
            chk("gate_a",   8'(gate_a),   8'(ea));
            chk("gate_b",   8'(gate_b),   8'(eb));
            chk("busy",     8'(busy),     8'(ebusy));
            chk("done",     8'(done),     8'(edone));
            chk("pass",     8'(pass),     8'(m_pass));
            chk("err_cnt",  8'(err_cnt),  8'(m_err));
            chk("fail_vec", 8'(fail_vec), 8'(m_fail));
        end
    end

    // One start pulse with gate function fn; checks done timing and results.
    task automatic sweep(input logic [3:0] fn, input logic [3:0] xfail,
                         input logic [2:0] xerr, input logic xpass);
        int n;
        @(negedge clk);
        gate_fn = fn;
        start   = 1'b1;
        @(negedge clk);            // cycle 1
        start = 1'b0;
        n = 1;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("done_cycle", 8'(n), 8'd13);
        @(negedge clk);            // cycle after done
        chk("res_fail_vec", 8'(fail_vec), 8'(xfail));
        chk("res_err_cnt",  8'(err_cnt),  8'(xerr));
        chk("res_pass",     8'(pass),     8'(xpass));
        $display("sweep fn=%b fail_vec=%b err_cnt=%0d pass=%0d done_cycle=%0d",
                 fn, fail_vec, err_cnt, pass, n);
    endtask

    initial begin
        int n;
        int dones[$];

        repeat (3) @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {gate_a, gate_b, busy, done, pass, err_cnt[2:0]}, 8'd0);
        chk("reset_fail_vec", 8'(fail_vec), 8'd0);
        rst_n = 1'b1;

        sweep(4'b0111, 4'b0000, 3'd0, 1'b1);   // NAND
        sweep(4'b1111, 4'b1000, 3'd1, 1'b0);   // tied 1
        sweep(4'b0000, 4'b0111, 3'd3, 1'b0);   // tied 0
        sweep(4'b1000, 4'b1111, 3'd4, 1'b0);   // AND

        // start held high for 30 cycles with NAND connected
        @(negedge clk);
        gate_fn = 4'b0111;
        start   = 1'b1;
        for (n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (done) dones.push_back(n);
            if (n == 28) chk("held_pass_c28", 8'(pass), 8'd1);
        end
        start = 1'b0;
        chk("held_done_count", 8'(dones.size()), 8'd2);
        if (dones.size() >= 2) begin
            chk("held_done1", 8'(dones[0]), 8'd13);
            chk("held_done2", 8'(dones[1]), 8'd27);
        end
        $display("held start: %0d done pulses", dones.size());
        n = 0;
        while ((busy || done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("held_drain_timeout", 8'(n < 100), 8'd1);

        // reset asserted at cycle 5 of a sweep
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);            // cycle 1
        start = 1'b0;
        repeat (4) @(negedge clk); // cycle 5
        rst_n = 1'b0;
        @(negedge clk);            // cycle 6
        chk("midreset_outputs", {gate_a, gate_b, busy, done, pass, err_cnt[2:0]}, 8'd0);
        chk("midreset_fail_vec", 8'(fail_vec), 8'd0);
        $display("mid-sweep reset: busy=%0d done=%0d", busy, done);
        rst_n = 1'b1;
        sweep(4'b0111, 4'b0000, 3'd0, 1'b1);

        // randomized phase: random starts, gate functions and resets
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            start = ($urandom_range(3) == 0);
            rst_n = ($urandom_range(79) != 0);
            if ($urandom_range(7) == 0) gate_fn = 4'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
